// File: rtl/data_sram_responder_if.sv
// Request/response bus between a data-side SRAM initiator (master) and the
// SRAM responder (slave).
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised SRAM model behind an addr_ok/data_ok handshake, with an
// in-order queue of accepted requests and a fixed response latency.
module data_sram_responder #(
  parameter int MEM_AW     = 10,
  parameter int LATENCY    = 1,
  parameter int PEND_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_responder_if.slave  bus
);
  localparam int DEPTH = 1 << MEM_AW;
  localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int NSLOT = 1 << PTR_W;

  logic [31:0]       mem_q [DEPTH];

  logic [2:0]        count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;

  logic              ent_vld_q   [NSLOT];
  logic              ent_wr_q    [NSLOT];
  logic [1:0]        ent_size_q  [NSLOT];
  logic [3:0]        ent_wstrb_q [NSLOT];
  logic [MEM_AW-1:0] ent_idx_q   [NSLOT];
  logic [31:0]       ent_wdata_q [NSLOT];
  logic [3:0]        ent_cd_q    [NSLOT];

  logic              addr_ok_s;
  logic              data_ok_s;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  // Handshake decode: everything is derived from registered queue state.
  always_comb begin
    addr_ok_s = 1'b0;
    data_ok_s = 1'b0;
    if (reset) begin
      addr_ok_s = 1'b0;
      data_ok_s = 1'b0;
    end else begin
      addr_ok_s = (count_q < 3'(PEND_DEPTH));
      data_ok_s = (count_q != 3'd0) && ent_vld_q[head_q] && (ent_cd_q[head_q] == 4'd0);
    end
    push_s = bus.data_sram_req && addr_ok_s;
    pop_s  = data_ok_s;
  end

  // Next-state for occupancy and the circular head/tail pointers.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (pop_s) begin
      head_d = (head_q == PTR_W'(PEND_DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = (tail_q == PTR_W'(PEND_DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
  end

  // Read data is the head word as it stands in the response cycle.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (data_ok_s && !ent_wr_q[head_q]) begin
      rdata_s = mem_q[ent_idx_q[head_q]];
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Pending-request queue: capture on handshake, count down, retire on data_ok.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 3'd0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        ent_vld_q[i]   <= 1'b0;
        ent_wr_q[i]    <= 1'b0;
        ent_size_q[i]  <= 2'd0;
        ent_wstrb_q[i] <= 4'd0;
        ent_idx_q[i]   <= '0;
        ent_wdata_q[i] <= 32'h0000_0000;
        ent_cd_q[i]    <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (ent_vld_q[i] && (ent_cd_q[i] != 4'd0)) begin
          ent_cd_q[i] <= ent_cd_q[i] - 4'd1;
        end
      end
      if (pop_s) begin
        ent_vld_q[head_q] <= 1'b0;
      end
      // Push and pop never share a slot: that would need the queue empty and full at once.
      if (push_s) begin
        ent_vld_q[tail_q]   <= 1'b1;
        ent_wr_q[tail_q]    <= bus.data_sram_wr;
        ent_size_q[tail_q]  <= bus.data_sram_size;
        ent_wstrb_q[tail_q] <= bus.data_sram_wstrb;
        ent_idx_q[tail_q]   <= bus.data_sram_addr[MEM_AW+1:2];
        ent_wdata_q[tail_q] <= bus.data_sram_wdata;
        ent_cd_q[tail_q]    <= 4'(LATENCY);
      end
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Byte-masked write commits at the edge that ends its data_ok cycle.
  always_ff @(posedge clk) begin
    if (data_ok_s && ent_wr_q[head_q]) begin
      for (int b = 0; b < 4; b++) begin
        if (ent_wstrb_q[head_q][b]) begin
          mem_q[ent_idx_q[head_q]][8*b +: 8] <= ent_wdata_q[head_q][8*b +: 8];
        end
      end
    end
  end

  assign unused_s = ^{bus.data_sram_addr[31:MEM_AW+2], bus.data_sram_addr[1:0],
                      ent_size_q[head_q]};

  assign bus.data_sram_addr_ok = addr_ok_s;
  assign bus.data_sram_data_ok = data_ok_s;
  assign bus.data_sram_rdata   = rdata_s;
endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder at three latency/depth settings.
module tb_data_sram_responder;
  logic        clk = 1'b0;
  logic        reset;
  int          sel;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok_m;
  logic        data_ok_m;
  logic [31:0] rdata_m;

  int          checks = 0;
  int          failures = 0;
  int          resp_cnt = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] exp_q [$];
  logic [31:0] model [int];

  data_sram_responder_if if_a ();
  data_sram_responder_if if_b ();
  data_sram_responder_if if_c ();

  data_sram_responder #(.MEM_AW(10), .LATENCY(1), .PEND_DEPTH(2)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a));
  data_sram_responder #(.MEM_AW(10), .LATENCY(3), .PEND_DEPTH(2)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b));
  data_sram_responder #(.MEM_AW(10), .LATENCY(0), .PEND_DEPTH(2)) u_dut_c (
    .clk(clk), .reset(reset), .bus(if_c));

  always #5 clk = ~clk;

  assign if_a.data_sram_req   = req && (sel == 0);
  assign if_b.data_sram_req   = req && (sel == 1);
  assign if_c.data_sram_req   = req && (sel == 2);
  assign if_a.data_sram_wr    = wr;
  assign if_b.data_sram_wr    = wr;
  assign if_c.data_sram_wr    = wr;
  assign if_a.data_sram_size  = size;
  assign if_b.data_sram_size  = size;
  assign if_c.data_sram_size  = size;
  assign if_a.data_sram_wstrb = wstrb;
  assign if_b.data_sram_wstrb = wstrb;
  assign if_c.data_sram_wstrb = wstrb;
  assign if_a.data_sram_addr  = addr;
  assign if_b.data_sram_addr  = addr;
  assign if_c.data_sram_addr  = addr;
  assign if_a.data_sram_wdata = wdata;
  assign if_b.data_sram_wdata = wdata;
  assign if_c.data_sram_wdata = wdata;

  always_comb begin
    case (sel)
      1: begin addr_ok_m = if_b.data_sram_addr_ok; data_ok_m = if_b.data_sram_data_ok; rdata_m = if_b.data_sram_rdata; end
      2: begin addr_ok_m = if_c.data_sram_addr_ok; data_ok_m = if_c.data_sram_data_ok; rdata_m = if_c.data_sram_rdata; end
      default: begin addr_ok_m = if_a.data_sram_addr_ok; data_ok_m = if_a.data_sram_data_ok; rdata_m = if_a.data_sram_rdata; end
    endcase
  end

  // Response monitor: pops the scoreboard on every data_ok of the selected DUT.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (!reset) begin
      checks++;
      if (data_ok_m === 1'b1) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_data_ok: dut=%0d data_ok=1 with nothing outstanding", sel);
        end else begin
          exp_v = exp_q.pop_front();
          if (rdata_m !== exp_v) begin
            failures++;
            $display("FAIL resp_rdata: dut=%0d got=%h expected=%h", sel, rdata_m, exp_v);
          end
          last_rdata = rdata_m;
          resp_cnt++;
        end
      end else if (rdata_m !== 32'h0) begin
        failures++;
        $display("FAIL idle_rdata: dut=%0d got=%h expected=00000000", sel, rdata_m);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit track, output int stalls);
    int          key;
    logic [31:0] word;
    wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2; req = 1'b1;
    stalls = 0;
    while (addr_ok_m !== 1'b1 && stalls < 40) begin
      @(negedge clk);
      stalls++;
    end
    if (addr_ok_m !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: dut=%0d addr=%h addr_ok=%b expected 1", sel, a, addr_ok_m);
      req = 1'b0;
    end else begin
      if (track) begin
        key = sel * 4096 + int'(a[11:2]);
        word = model.exists(key) ? model[key] : 32'h0;
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
          model[key] = word;
          exp_q.push_back(32'h0);
        end else begin
          exp_q.push_back(word);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    req = 1'b0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: dut=%0d outstanding=%0d expected 0", sel, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if ({if_a.data_sram_addr_ok, if_b.data_sram_addr_ok, if_c.data_sram_addr_ok} !== 3'b000) begin
      failures++; $display("FAIL reset_addr_ok: got=%b expected=000", {if_a.data_sram_addr_ok, if_b.data_sram_addr_ok, if_c.data_sram_addr_ok});
    end
    if ({if_a.data_sram_data_ok, if_b.data_sram_data_ok, if_c.data_sram_data_ok} !== 3'b000) begin
      failures++; $display("FAIL reset_data_ok: got=%b expected=000", {if_a.data_sram_data_ok, if_b.data_sram_data_ok, if_c.data_sram_data_ok});
    end
    if ((if_a.data_sram_rdata | if_b.data_sram_rdata | if_c.data_sram_rdata) !== 32'h0) begin
      failures++; $display("FAIL reset_rdata: got=%h expected=00000000", if_a.data_sram_rdata | if_b.data_sram_rdata | if_c.data_sram_rdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({if_a.data_sram_addr_ok, if_b.data_sram_addr_ok, if_c.data_sram_addr_ok} !== 3'b111) begin
      failures++; $display("FAIL post_reset_addr_ok: got=%b expected=111", {if_a.data_sram_addr_ok, if_b.data_sram_addr_ok, if_c.data_sram_addr_ok});
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int st;
    sel = 0;
    issue(1'b1, 32'h10, 32'h1122_3344, 4'hF, 1'b1, st);
    req = 1'b0;
    checks++;
    if (data_ok_m !== 1'b0) begin failures++; $display("FAIL wr_latency_early: data_ok=%b expected 0", data_ok_m); end
    @(negedge clk);
    checks++;
    if (data_ok_m !== 1'b1) begin failures++; $display("FAIL wr_latency_due: data_ok=%b expected 1", data_ok_m); end
    drain();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, st);
    drain();
    checks++;
    if (last_rdata !== 32'h1122_3344) begin failures++; $display("FAIL full_word_read: got=%h expected=11223344", last_rdata); end
  endtask

  task automatic test_partial_write();
    int st;
    sel = 0;
    issue(1'b1, 32'h12, 32'hAABB_CCDD, 4'h4, 1'b1, st);
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, st);
    drain();
    checks++;
    if (last_rdata !== 32'h11BB_3344) begin failures++; $display("FAIL partial_write: got=%h expected=11bb3344", last_rdata); end
    issue(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b1, st);
    issue(1'b0, 32'h13, 32'h0, 4'h0, 1'b1, st);
    drain();
    checks++;
    if (last_rdata !== 32'h11BB_3344) begin failures++; $display("FAIL zero_strobe: got=%h expected=11bb3344", last_rdata); end
  endtask

  task automatic test_wrap();
    int st;
    sel = 0;
    issue(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 1'b1, st);
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b1, st);
    drain();
    checks++;
    if (last_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL addr_wrap: got=%h expected=cafef00d", last_rdata); end
  endtask

  task automatic test_pend_full();
    int st;
    sel = 1;
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h100 + 32'(4 * i), 32'h5A00_0000 + 32'(i), 4'hF, 1'b1, st);
    drain();
    issue(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, st);
    issue(1'b0, 32'h104, 32'h0, 4'h0, 1'b1, st);
    issue(1'b0, 32'h108, 32'h0, 4'h0, 1'b1, st);
    checks++;
    if (st !== 3) begin failures++; $display("FAIL full_stall: third read stalled=%0d cycles expected 3", st); end
    drain();
    checks++;
    if (last_rdata !== 32'h5A00_0002) begin failures++; $display("FAIL full_order_last: got=%h expected=5a000002", last_rdata); end
  endtask

  task automatic test_back_to_back();
    int st;
    int total;
    int r0;
    sel = 2;
    total = 0;
    r0 = resp_cnt;
    for (int i = 0; i < 8; i++) begin
      issue(i < 4, 32'h200 + 32'(4 * (i % 4)), 32'h0BAD_0000 + 32'(i * 17), 4'hF, 1'b1, st);
      total += st;
    end
    req = 1'b0;
    #1;
    checks += 2;
    if (total !== 0) begin failures++; $display("FAIL b2b_stalls: got=%0d expected 0", total); end
    if (resp_cnt - r0 !== 8) begin failures++; $display("FAIL b2b_responses: got=%0d expected 8", resp_cnt - r0); end
    drain();
  endtask

  task automatic test_reset_pending();
    int st;
    sel = 1;
    issue(1'b1, 32'h40, 32'h0101_0101, 4'hF, 1'b1, st);
    issue(1'b1, 32'h44, 32'h0202_0202, 4'hF, 1'b1, st);
    drain();
    issue(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0, st);
    issue(1'b1, 32'h44, 32'hDEAD_BEEF, 4'hF, 1'b0, st);
    req = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({addr_ok_m, data_ok_m} !== 2'b00 || rdata_m !== 32'h0) begin
        failures++; $display("FAIL rst_pending_outputs: addr_ok=%b data_ok=%b rdata=%h expected 0", addr_ok_m, data_ok_m, rdata_m);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (addr_ok_m !== 1'b1) begin failures++; $display("FAIL rst_release_addr_ok: got=%b expected 1", addr_ok_m); end
    repeat (6) @(negedge clk);
    issue(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, st);
    issue(1'b0, 32'h44, 32'h0, 4'h0, 1'b1, st);
    drain();
    checks++;
    if (last_rdata !== 32'h0202_0202) begin failures++; $display("FAIL rst_mem_kept: got=%h expected=02020202", last_rdata); end
  endtask

  initial begin
    sel = 0; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_partial_write();
    test_wrap();
    test_pend_full();
    test_back_to_back();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
